// File: rtl/x25519_ladder_sequencer_if.sv
// Ladder-step core handshake: the sequencer is the master, the step core the slave.
interface x25519_ladder_sequencer_if #(
  parameter int ELEM_WIDTH = 256
);
  logic                      step_en;
  logic                      step_b;
  logic [2*ELEM_WIDTH-1:0]   step_xzm;
  logic [2*ELEM_WIDTH-1:0]   step_xzm1;
  logic [ELEM_WIDTH+7:0]     step_work;
  logic                      step_valid;
  logic [2*ELEM_WIDTH-1:0]   step_xzm_in;
  logic [2*ELEM_WIDTH-1:0]   step_xzm1_in;

  modport master (
    output step_en, step_b, step_xzm, step_xzm1, step_work,
    input  step_valid, step_xzm_in, step_xzm1_in
  );

  modport slave (
    input  step_en, step_b, step_xzm, step_xzm1, step_work,
    output step_valid, step_xzm_in, step_xzm1_in
  );
endinterface

// File: rtl/x25519_ladder_sequencer.sv
// Montgomery ladder sequencer: one step-core request per scalar bit, MSB first.
// Define X25519_SCALAR_CLAMP_EN to apply RFC 7748 scalar clamping on start.
module x25519_ladder_sequencer #(
  parameter int ELEM_WIDTH      = 256,
  parameter int SCALAR_BITS     = 256,
  parameter int START_BIT       = 254,
  parameter int WATCHDOG_CYCLES = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [SCALAR_BITS-1:0]  scalar_i,
  input  logic [ELEM_WIDTH-1:0]   u_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [2*ELEM_WIDTH-1:0] xzm_o,
  output logic [2*ELEM_WIDTH-1:0] xzm1_o,
  x25519_ladder_sequencer_if.master step_if
);

  localparam int POS_W = $clog2(SCALAR_BITS);
  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [POS_W-1:0] POS_START = POS_W'(START_BIT);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_e;

  state_e                  state_q;
  logic [SCALAR_BITS-1:0]  scalar_q;
  logic [SCALAR_BITS-1:0]  scalar_d;
  logic [ELEM_WIDTH-1:0]   u_q;
  logic [2*ELEM_WIDTH-1:0] xzm_q;
  logic [2*ELEM_WIDTH-1:0] xzm1_q;
  logic [2*ELEM_WIDTH-1:0] xzm_out_q;
  logic [2*ELEM_WIDTH-1:0] xzm1_out_q;
  logic [POS_W-1:0]        pos_q;
  logic [WD_W-1:0]         wd_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic                    step_en_q;
  logic                    step_b_q;

`ifdef X25519_SCALAR_CLAMP_EN
  if (SCALAR_BITS < 256) begin : g_clamp_width_check
    $fatal(1, "x25519_ladder_sequencer: clamping needs SCALAR_BITS >= 256");
  end

  always_comb begin
    scalar_d      = scalar_i;
    scalar_d[2:0] = 3'b000;
    scalar_d[255] = 1'b0;
    scalar_d[254] = 1'b1;
  end
`else
  always_comb begin
    scalar_d = scalar_i;
  end
`endif

  // The watchdog counts from the ISSUE cycle, so it measures step_en to step_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scalar_q   <= '0;
      u_q        <= '0;
      xzm_q      <= '0;
      xzm1_q     <= '0;
      xzm_out_q  <= '0;
      xzm1_out_q <= '0;
      pos_q      <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      step_en_q  <= 1'b0;
      step_b_q   <= 1'b0;
    end else begin
      step_en_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            scalar_q  <= scalar_d;
            u_q       <= u_i;
            xzm_q     <= {ELEM_WIDTH'(0), ELEM_WIDTH'(1)};
            xzm1_q    <= {ELEM_WIDTH'(1), u_i};
            pos_q     <= POS_START;
            wd_q      <= '0;
            busy_q    <= 1'b1;
            step_en_q <= 1'b1;
            step_b_q  <= scalar_d[START_BIT];
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= wd_q + WD_W'(1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (step_if.step_valid) begin
            xzm_q  <= step_if.step_xzm_in;
            xzm1_q <= step_if.step_xzm1_in;
            if (pos_q == '0) begin
              xzm_out_q  <= step_if.step_xzm_in;
              xzm1_out_q <= step_if.step_xzm1_in;
              done_q     <= 1'b1;
              state_q    <= FINISH;
            end else begin
              pos_q     <= pos_q - POS_W'(1);
              wd_q      <= '0;
              step_en_q <= 1'b1;
              step_b_q  <= scalar_q[pos_q - POS_W'(1)];
              state_q   <= ISSUE;
            end
          end else if (wd_q == WD_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;
  assign xzm_o   = xzm_out_q;
  assign xzm1_o  = xzm1_out_q;

  assign step_if.step_en   = step_en_q;
  assign step_if.step_b    = step_b_q;
  assign step_if.step_xzm  = xzm_q;
  assign step_if.step_xzm1 = xzm1_q;
  assign step_if.step_work = {8'h00, u_q};

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Directed bench for the ladder sequencer using a stub step core that adds 1 to xzm
// and 2 to xzm1 per step, so final results encode the number of accepted steps.
module tb_x25519_ladder_sequencer;

  localparam int EW = 32;
  localparam int SB = 256;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SB-1:0]   scalar;
  logic [EW-1:0]   u;
  logic            busy;
  logic            done;
  logic            error;
  logic [2*EW-1:0] xzmOut;
  logic [2*EW-1:0] xzm1Out;

  x25519_ladder_sequencer_if #(.ELEM_WIDTH(EW)) stepIf();

  x25519_ladder_sequencer #(
    .ELEM_WIDTH(EW),
    .SCALAR_BITS(SB),
    .START_BIT(254),
    .WATCHDOG_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .scalar_i(scalar),
    .u_i(u),
    .busy_o(busy),
    .done_o(done),
    .error_o(error),
    .xzm_o(xzmOut),
    .xzm1_o(xzm1Out),
    .step_if(stepIf)
  );

  localparam logic [SB-1:0]   SCALAR_A  = 256'h5;
  localparam logic [EW-1:0]   U_A       = 32'h0000_1234;
  localparam logic [2*EW-1:0] EXP_XZM   = 64'h0000_0000_0000_0100;
  localparam logic [2*EW-1:0] EXP_XZM1  = 64'h0000_0001_0000_1432;

  int checks = 0;
  int errors = 0;

  int  cycle = 0;
  int  stepCount = 0;
  int  doneCount = 0;
  int  errorCount = 0;
  int  doubleEn = 0;
  int  enCycle = 0;
  int  errCycle = 0;
  logic busyAtDone = 1'b0;
  logic prevEn = 1'b0;
  logic stepBits [0:511];
  logic [2*EW-1:0] firstXzm;
  logic [2*EW-1:0] firstXzm1;
  logic [EW+7:0]   firstWork;

  bit stubEnable = 1'b1;
  int stubLatency = 5;
  bit stubPending = 1'b0;
  int stubCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub step core: one outstanding request, answers stubLatency cycles after step_en.
  initial begin
    stepIf.step_valid   = 1'b0;
    stepIf.step_xzm_in  = '0;
    stepIf.step_xzm1_in = '0;
    forever begin
      @(negedge clk);
      stepIf.step_valid = 1'b0;
      if (stubPending) begin
        if (stubCount <= 1) begin
          stepIf.step_valid   = 1'b1;
          stepIf.step_xzm_in  = stepIf.step_xzm + 64'd1;
          stepIf.step_xzm1_in = stepIf.step_xzm1 + 64'd2;
          stubPending = 1'b0;
        end else begin
          stubCount--;
        end
      end else if (stepIf.step_en && stubEnable) begin
        stubPending = 1'b1;
        stubCount   = stubLatency;
      end
    end
  end

  // Monitor samples just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (stepIf.step_en) begin
        if (prevEn) doubleEn++;
        stepCount++;
        if (stepCount < 512) stepBits[stepCount] = stepIf.step_b;
        if (stepCount == 1) begin
          firstXzm  = stepIf.step_xzm;
          firstXzm1 = stepIf.step_xzm1;
          firstWork = stepIf.step_work;
          enCycle   = cycle;
        end
      end
      prevEn = stepIf.step_en;
      if (done) begin
        doneCount++;
        busyAtDone = busy;
      end
      if (error) begin
        errorCount++;
        errCycle = cycle;
      end
    end
  end

  task automatic clearCounters();
    stepCount  = 0;
    doneCount  = 0;
    errorCount = 0;
    doubleEn   = 0;
    busyAtDone = 1'b0;
    for (int i = 0; i < 512; i++) stepBits[i] = 1'b0;
  endtask

  task automatic applyStimulus(input logic [SB-1:0] s, input logic [EW-1:0] uv);
    @(negedge clk);
    scalar = s;
    u      = uv;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitSteps(input int target, input int bound, input string name);
    int n = 0;
    while (stepCount < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (stepCount < target) begin
      errors++;
      $display("[TB] FAIL %s: timeout, steps=%0d required=%0d", name, stepCount, target);
    end
  endtask

  task automatic waitDone(input int bound, input string name);
    int n = 0;
    while (doneCount == 0 && errorCount == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (doneCount == 0) begin
      errors++;
      $display("[TB] FAIL %s: no done, done=%0d required=1 (errors seen %0d)", name, doneCount, errorCount);
    end
  endtask

  function automatic int patternErrors(input logic [SB-1:0] s);
    int n = 0;
    for (int k = 1; k <= 255; k++) begin
      if (stepBits[k] !== s[255-k]) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset error: got %b want 0", error); end
    checks++; if (stepIf.step_en !== 1'b0) begin errors++; $display("[TB] FAIL reset step_en: got %b want 0", stepIf.step_en); end
    checks++; if (xzmOut !== '0) begin errors++; $display("[TB] FAIL reset xzm_out: got %h want 0", xzmOut); end
    checks++; if (xzm1Out !== '0) begin errors++; $display("[TB] FAIL reset xzm1_out: got %h want 0", xzm1Out); end
  endtask

  task automatic test_sequencing();
    int pe;
    clearCounters();
    applyStimulus(SCALAR_A, U_A);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL seq busy after start: got %b want 1", busy); end
    waitDone(5000, "seq done");
    repeat (4) @(negedge clk);
    pe = patternErrors(SCALAR_A);
    checks++; if (stepCount !== 255) begin errors++; $display("[TB] FAIL seq step count: got %0d want 255", stepCount); end
    checks++; if (pe !== 0) begin errors++; $display("[TB] FAIL seq step_b pattern: got %0d wrong bits want 0", pe); end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL seq done pulses: got %0d want 1", doneCount); end
    checks++; if (doubleEn !== 0) begin errors++; $display("[TB] FAIL seq step_en width: got %0d long pulses want 0", doubleEn); end
    checks++; if (busyAtDone !== 1'b1) begin errors++; $display("[TB] FAIL seq busy at done: got %b want 1", busyAtDone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL seq busy after done: got %b want 0", busy); end
    checks++; if (firstXzm !== 64'h0000_0000_0000_0001) begin errors++; $display("[TB] FAIL seq initial xzm: got %h want 1", firstXzm); end
    checks++; if (firstXzm1 !== 64'h0000_0001_0000_1234) begin errors++; $display("[TB] FAIL seq initial xzm1: got %h want 0000000100001234", firstXzm1); end
    checks++; if (firstWork !== 40'h00_0000_1234) begin errors++; $display("[TB] FAIL seq step_work: got %h want 0000001234", firstWork); end
    checks++; if (xzmOut !== EXP_XZM) begin errors++; $display("[TB] FAIL seq xzm_out: got %h want %h", xzmOut, EXP_XZM); end
    checks++; if (xzm1Out !== EXP_XZM1) begin errors++; $display("[TB] FAIL seq xzm1_out: got %h want %h", xzm1Out, EXP_XZM1); end
  endtask

  task automatic test_busy_start();
    int pe;
    clearCounters();
    applyStimulus(SCALAR_A, U_A);
    waitSteps(10, 200, "busy start reach step 10");
    applyStimulus({SB{1'b1}}, 32'h0000_BEEF);
    waitDone(5000, "busy start done");
    repeat (4) @(negedge clk);
    pe = patternErrors(SCALAR_A);
    checks++; if (stepCount !== 255) begin errors++; $display("[TB] FAIL busy start step count: got %0d want 255", stepCount); end
    checks++; if (pe !== 0) begin errors++; $display("[TB] FAIL busy start step_b pattern: got %0d wrong bits want 0", pe); end
    checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL busy start done pulses: got %0d want 1", doneCount); end
    checks++; if (xzm1Out !== EXP_XZM1) begin errors++; $display("[TB] FAIL busy start xzm1_out: got %h want %h", xzm1Out, EXP_XZM1); end
  endtask

  task automatic test_watchdog();
    int n = 0;
    stubEnable = 1'b0;
    clearCounters();
    applyStimulus(SCALAR_A, U_A);
    while (errorCount == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (errorCount !== 1) begin errors++; $display("[TB] FAIL watchdog error pulses: got %0d want 1", errorCount); end
    checks++; if (errCycle - enCycle !== 16) begin errors++; $display("[TB] FAIL watchdog delay: got %0d cycles want 16", errCycle - enCycle); end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL watchdog busy: got %b want 0", busy); end
    checks++; if (doneCount !== 0) begin errors++; $display("[TB] FAIL watchdog done pulses: got %0d want 0", doneCount); end
    checks++; if (stepCount !== 1) begin errors++; $display("[TB] FAIL watchdog step count: got %0d want 1", stepCount); end
    checks++; if (xzmOut !== EXP_XZM) begin errors++; $display("[TB] FAIL watchdog xzm_out held: got %h want %h", xzmOut, EXP_XZM); end
    stubEnable = 1'b1;
  endtask

  task automatic test_watchdog_edge();
    stubLatency = 15;
    clearCounters();
    applyStimulus(SCALAR_A, U_A);
    waitDone(10000, "watchdog edge done");
    repeat (4) @(negedge clk);
    checks++; if (errorCount !== 0) begin errors++; $display("[TB] FAIL watchdog edge error pulses: got %0d want 0", errorCount); end
    checks++; if (stepCount !== 255) begin errors++; $display("[TB] FAIL watchdog edge step count: got %0d want 255", stepCount); end
    checks++; if (xzmOut !== EXP_XZM) begin errors++; $display("[TB] FAIL watchdog edge xzm_out: got %h want %h", xzmOut, EXP_XZM); end
    stubLatency = 5;
  endtask

  task automatic test_reset_mid();
    clearCounters();
    applyStimulus(SCALAR_A, U_A);
    waitSteps(100, 2000, "reset mid reach step 100");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset mid busy: got %b want 0", busy); end
    checks++; if (xzmOut !== '0) begin errors++; $display("[TB] FAIL reset mid xzm_out: got %h want 0", xzmOut); end
    repeat (12) @(negedge clk);
    checks++; if (stepCount !== 100) begin errors++; $display("[TB] FAIL reset mid late valid steps: got %0d want 100", stepCount); end
    checks++; if (doneCount !== 0) begin errors++; $display("[TB] FAIL reset mid done pulses: got %0d want 0", doneCount); end
    clearCounters();
    applyStimulus(SCALAR_A, U_A);
    waitDone(5000, "reset mid rerun done");
    repeat (4) @(negedge clk);
    checks++; if (stepCount !== 255) begin errors++; $display("[TB] FAIL reset mid rerun steps: got %0d want 255", stepCount); end
    checks++; if (xzmOut !== EXP_XZM) begin errors++; $display("[TB] FAIL reset mid rerun xzm_out: got %h want %h", xzmOut, EXP_XZM); end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    scalar = '0;
    u      = '0;
    test_reset();
    test_sequencing();
    test_busy_start();
    test_watchdog();
    test_watchdog_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
